// File: rtl/multicast_tag_sequencer_if.sv
// Upstream valid/ready word port and shared multicast bus of the tag sequencer.
// master = sequencer side, slave = upstream source plus controller array.
interface multicast_tag_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned BITWIDTH      = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDRESS_WIDTH-1:0] in_tag;
  logic [BITWIDTH-1:0]      in_data;
  logic                     bus_enable;
  logic [ADDRESS_WIDTH-1:0] bus_tag;
  logic [BITWIDTH-1:0]      bus_value;
  logic                     bus_ack;

  modport master (
    input  in_valid, in_tag, in_data, bus_ack,
    output in_ready, bus_enable, bus_tag, bus_value
  );

  modport slave (
    output in_valid, in_tag, in_data, bus_ack,
    input  in_ready, bus_enable, bus_tag, bus_value
  );
endinterface

// File: rtl/multicast_tag_sequencer.sv
// Programs a scan-chained multicast controller array from a tag table, then streams tagged
// words onto the shared bus, holding each until acknowledged or timed out.
module multicast_tag_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned BITWIDTH      = 16,
  parameter int unsigned NUM_UNITS     = 8,
  parameter int unsigned TIMEOUT       = 15,
  localparam int unsigned IdxW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstb,
  input  logic                     cfg_we_i,
  input  logic [IdxW-1:0]          cfg_idx_i,
  input  logic [ADDRESS_WIDTH-1:0] cfg_tag_i,
  input  logic                     start_program_i,
  output logic                     busy_o,
  output logic                     programmed_o,
  output logic                     program_o,
  output logic [ADDRESS_WIDTH-1:0] scan_tag_o,
  output logic                     drop_err_o,
  output logic [7:0]               drop_count_o,
  multicast_tag_sequencer_if.master bus_if
);

  localparam int unsigned PulseW = $clog2(2 * NUM_UNITS);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(2 * NUM_UNITS - 1);
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StShift, StRun} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] table_q [NUM_UNITS];
  logic [ADDRESS_WIDTH-1:0] table_d [NUM_UNITS];
  logic [PulseW-1:0]        pulse_q, pulse_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic                     pending_q, pending_d;
  logic                     programmed_q, programmed_d;
  logic                     program_q, program_d;
  logic                     busy_q, busy_d;
  logic [ADDRESS_WIDTH-1:0] scan_tag_q, scan_tag_d;
  logic [ADDRESS_WIDTH-1:0] bus_tag_q, bus_tag_d;
  logic [BITWIDTH-1:0]      bus_value_q, bus_value_d;
  logic                     drop_err_q, drop_err_d;
  logic [7:0]               drop_count_q, drop_count_d;

  logic              in_ready;
  logic              idx_in_range;
  logic              start_ok;
  logic              cfg_ok;
  logic              accept;
  logic              shift_step;
  logic [PulseW-1:0] pulse_nxt;
  logic [IdxW-1:0]   scan_idx;

  if (NUM_UNITS == (1 << IdxW)) begin : g_idx_full
    assign idx_in_range = 1'b1;
  end else begin : g_idx_part
    assign idx_in_range = (cfg_idx_i < IdxW'(NUM_UNITS));
  end

  assign in_ready = (state_q == StRun) && !pending_q;

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    pulse_d      = pulse_q;
    wait_d       = wait_q;
    pending_d    = pending_q;
    programmed_d = programmed_q;
    program_d    = 1'b0;
    busy_d       = 1'b0;
    scan_tag_d   = '0;
    bus_tag_d    = bus_tag_q;
    bus_value_d  = bus_value_q;
    drop_err_d   = 1'b0;
    drop_count_d = drop_count_q;

    start_ok = start_program_i && ((state_q == StIdle) || ((state_q == StRun) && !pending_q));
    // A write coinciding with SHIFT entry would race the scan-out, so it is dropped.
    cfg_ok   = cfg_we_i && (state_q != StShift) && !start_ok && idx_in_range;
    // start_program wins over a word offered in the same cycle; that word is discarded.
    accept   = in_ready && bus_if.in_valid && !start_ok;

    shift_step = start_ok || ((state_q == StShift) && (pulse_q != PulseLast));
    pulse_nxt  = (state_q == StShift) ? pulse_q + 1'b1 : PulseW'(1);
    // Odd pulse p carries table[(P-p)/2]: farthest unit first, unit 0 on the last pulse.
    scan_idx   = IdxW'((PulseLast - pulse_nxt) >> 1);

    if (cfg_ok) begin
      table_d[cfg_idx_i] = cfg_tag_i;
      programmed_d       = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (shift_step) state_d = StShift;
      end
      StShift: begin
        if (!shift_step) begin
          state_d      = StRun;
          programmed_d = 1'b1;
          pulse_d      = '0;
        end
      end
      StRun: begin
        if (shift_step) begin
          state_d = StShift;
        end else if (pending_q) begin
          if (bus_if.bus_ack) begin
            pending_d   = 1'b0;
            bus_tag_d   = '0;
            bus_value_d = '0;
          end else if (wait_q == WaitLast) begin
            pending_d   = 1'b0;
            bus_tag_d   = '0;
            bus_value_d = '0;
            drop_err_d  = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else if (accept) begin
          pending_d   = 1'b1;
          wait_d      = '0;
          bus_tag_d   = bus_if.in_tag;
          bus_value_d = bus_if.in_data;
        end
      end
      default: state_d = StIdle;
    endcase

    if (shift_step) begin
      busy_d       = 1'b1;
      program_d    = 1'b1;
      programmed_d = 1'b0;
      pulse_d      = pulse_nxt;
      scan_tag_d   = pulse_nxt[0] ? table_q[scan_idx] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      table_q      <= '{default: '0};
      pulse_q      <= '0;
      wait_q       <= '0;
      pending_q    <= 1'b0;
      programmed_q <= 1'b0;
      program_q    <= 1'b0;
      busy_q       <= 1'b0;
      scan_tag_q   <= '0;
      bus_tag_q    <= '0;
      bus_value_q  <= '0;
      drop_err_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      pulse_q      <= pulse_d;
      wait_q       <= wait_d;
      pending_q    <= pending_d;
      programmed_q <= programmed_d;
      program_q    <= program_d;
      busy_q       <= busy_d;
      scan_tag_q   <= scan_tag_d;
      bus_tag_q    <= bus_tag_d;
      bus_value_q  <= bus_value_d;
      drop_err_q   <= drop_err_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign busy_o            = busy_q;
  assign programmed_o      = programmed_q;
  assign program_o         = program_q;
  assign scan_tag_o        = scan_tag_q;
  assign drop_err_o        = drop_err_q;
  assign drop_count_o      = drop_count_q;
  assign bus_if.in_ready   = in_ready;
  assign bus_if.bus_enable = pending_q;
  assign bus_if.bus_tag    = bus_tag_q;
  assign bus_if.bus_value  = bus_value_q;

endmodule
